// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write sequencer: FSM encoding and address-byte helpers.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT_BYTE,
    ST_NEXT,
    ST_STOP,
    ST_WAIT_STOP,
    ST_DONE
  } seq_state_t;

  localparam logic I2C_WRITE_BIT   = 1'b0;
  localparam int   I2C_ADDR_W      = 7;
  localparam int   I2C_ADDR_BYTE_W = I2C_ADDR_W + 1;

  function automatic logic [I2C_ADDR_BYTE_W-1:0] addr_byte(input logic [I2C_ADDR_W-1:0] addr);
    return {addr, I2C_WRITE_BIT};
  endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// DEPTH-deep circular byte buffer with full/empty/count; the head byte is visible
// combinationally on rd_data so a pop and its data share one cycle.
module i2c_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/i2c_write_sequencer.sv
// Runs one I2C write (START, address+W, buffered payload, STOP) through the byte-level master.
// Optional per-byte watchdog and err flag are built only with I2C_SEQ_TIMEOUT_EN defined.
module i2c_write_sequencer
  import i2c_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       buf_wr,
  input  logic [7:0]                 buf_wdata,
  output logic                       buf_full,
  output logic [$clog2(DEPTH):0]     buf_count,
  output logic                       buf_ovf,
  input  logic                       cmd_go,
  input  logic [I2C_ADDR_W-1:0]      cmd_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [I2C_ADDR_BYTE_W-1:0] m_tx_data,
  output logic                       m_start,
  output logic                       m_stop,
  output logic                       m_i2c_en,
  input  logic                       m_ready,
  input  logic                       m_tx_done
);
  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_params
    $error("i2c_write_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end

  seq_state_t    state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          ovf_q, ovf_d;
  logic          stop_settle_q, stop_settle_d;
  logic          fifo_wr, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          go;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT) + 1;
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign m_i2c_en  = busy;
  assign buf_ovf   = ovf_q;
  assign buf_full  = fifo_full;
  assign buf_count = fifo_count;
  assign go        = cmd_go && (state_q == ST_IDLE);
  assign fifo_wr   = buf_wr && !fifo_full && !busy;
  assign m_tx_data = fifo_pop ? fifo_head : tx_data_q;

  i2c_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (buf_wdata),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // m_start/m_stop are combinational on m_ready so the request lands in the same cycle the master is ready.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    tx_data_d     = tx_data_q;
    ovf_d         = ovf_q;
    stop_settle_d = stop_settle_q;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;
    m_start       = 1'b0;
    m_stop        = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
    err_d         = err_q;
    wd_d          = '0;
`endif

    if (go) ovf_d = 1'b0;
    if (buf_wr && !fifo_wr) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          tx_data_d = addr_byte(cmd_addr);
          rem_d     = fifo_count;
          state_d   = ST_ADDR;
`ifdef I2C_SEQ_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      ST_ADDR: begin
        if (m_ready) begin
          m_start = 1'b1;
          state_d = ST_WAIT_BYTE;
        end
      end
      ST_WAIT_BYTE: begin
        if (m_tx_done) state_d = (rem_q != '0 && !fifo_empty) ? ST_NEXT : ST_STOP;
      end
      ST_NEXT: begin
        if (m_ready) begin
          fifo_pop  = 1'b1;
          m_start   = 1'b1;
          tx_data_d = fifo_head;
          rem_d     = rem_q - CW'(1);
          state_d   = ST_WAIT_BYTE;
        end
      end
      ST_STOP: begin
        if (m_ready) begin
          m_stop        = 1'b1;
          stop_settle_d = 1'b1;
          state_d       = ST_WAIT_STOP;
        end
      end
      ST_WAIT_STOP: begin
        if (stop_settle_q) stop_settle_d = 1'b0;
        else if (m_ready)  state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef I2C_SEQ_TIMEOUT_EN
    if ((state_q == ST_WAIT_BYTE || state_q == ST_WAIT_STOP) && state_d == state_q) begin
      if (wd_q == WW'(TIMEOUT - 1)) begin
        err_d         = 1'b1;
        fifo_flush    = 1'b1;
        stop_settle_d = 1'b0;
        state_d       = ST_IDLE;
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rem_q         <= '0;
      tx_data_q     <= '0;
      ovf_q         <= 1'b0;
      stop_settle_q <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      err_q         <= 1'b0;
      wd_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      tx_data_q     <= tx_data_d;
      ovf_q         <= ovf_d;
      stop_settle_q <= stop_settle_d;
`ifdef I2C_SEQ_TIMEOUT_EN
      err_q         <= err_d;
      wd_q          <= wd_d;
`endif
    end
  end

endmodule
